regfile_onehot_wr: RTL and testbench
====================================

Name: regfile_onehot_wr

Overview:
- 32-entry register file directly downstream of the 5-to-32 write-address decoder.
- Consumes the decoder's one-hot write-select vector plus write-back data.
- Provides two combinational read ports to the operand-fetch stage.
- Register 0 is hardwired to zero. A non-one-hot write select is detected, the write is suppressed, and a sticky error is flagged.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- NREGS, 32, number of registers; equals the width of WrSel.
- ADDR_W, 5, width of the read addresses; log2(NREGS).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- WrEn  input  1  write strobe from the write-back stage.
- WrSel  input  NREGS  one-hot write select from the decoder.
- WrData  input  DATA_W  write-back data.
- RdAdrA  input  ADDR_W  read address, port A.
- RdAdrB  input  ADDR_W  read address, port B.
- RdDataA  output  DATA_W  read data, port A (combinational).
- RdDataB  output  DATA_W  read data, port B (combinational).
- SelErr  output  1  sticky flag: a write with an illegal select was attempted.
- WrCount  output  16  number of committed writes, saturating.

Behaviour:
- Reset (Rst_n low, asynchronous, any time):
  - All registers clear to 0.
  - SelErr = 0 and WrCount = 0.
  - RdDataA/B read 0 while reset is held.
- Write validity: a write is valid iff WrEn=1 and WrSel has exactly one bit set (popcount == 1).
- Valid write:
  - At the rising edge of Clk, reg[i] <= WrData, where WrSel[i]=1.
  - If i=0, the write is discarded and reg[0] stays 0.
  - WrCount increments for every valid write to i != 0, saturating at 16'hFFFF.
- Invalid write (WrEn=1 and WrSel is zero or has more than one bit set):
  - No register changes.
  - SelErr <= 1 at that edge and stays 1 until reset.
  - WrCount unchanged.
- WrEn=0: WrSel is ignored entirely; there is no error check.
- Reads:
  - Combinational: RdDataX = reg[RdAdrX], with address 0 always returning 0.
  - Base behaviour is read-before-write: a read of a register being written in the same cycle returns the old value.
  - The new value is visible after the edge.
- Both read ports may address the same register, and may address the register being written; each port is resolved independently.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Reset released: the first edge with Rst_n high may commit a write.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - Applies when a valid write targets i != 0 and RdAdrX == i.
  - In that case RdDataX = WrData in the same cycle (combinational bypass).
  - Invalid writes and writes to register 0 are never forwarded.
- Undefined: pure read-before-write as specified above; no bypass mux is generated.

Decomposition:
- Shared package: NREGS, ADDR_W, DATA_W constants, the WrCount width (16), and the REG_ZERO index constant (0).
- One sub-module: onehot_chk.
  - Input: NREGS-bit vector.
  - Outputs: valid (popcount == 1) and a binary index (ADDR_W).
  - The index drives WrCount qualification and the bypass compare.
  - Instantiated once.

Test Plan:
- Reset then read:
  - Assert Rst_n=0 mid-run after writing 32'hDEADBEEF to reg 5.
  - Required: reg 5 reads 0; RdDataA/B = 0; SelErr = 0; WrCount = 0.
- Basic write and dual read:
  - WrEn=1, WrSel=32'h0000_0008, WrData=32'h1234_5678.
  - Next cycle, RdAdrA=3 and RdAdrB=3.
  - Required: both ports read 32'h1234_5678; WrCount = 1.
- Register 0 protection:
  - WrEn=1, WrSel=32'h0000_0001, WrData=32'hFFFF_FFFF.
  - Required: RdAdrA=0 reads 0; WrCount unchanged; SelErr = 0.
- Illegal selects:
  - Case 1: WrEn=1, WrSel=32'h0000_0006, WrData=32'hAAAA_AAAA.
  - Required: reg1 and reg2 unchanged; SelErr = 1 and stays 1.
  - Case 2: WrSel=0 with WrEn=1 also sets SelErr.
  - Case 3: WrSel=32'h0000_0006 with WrEn=0 leaves SelErr = 0.
- Same-cycle read/write:
  - reg 7 holds 32'h1; write 32'h2 to reg 7 while RdAdrA=7.
  - Required: RdDataA = 1 without REGFILE_BYPASS_EN; RdDataA = 2 with it defined.
  - After the edge, both builds read 2.
- Saturation and reset race:
  - Force 65535 valid writes, then one more.
  - Required: WrCount = 16'hFFFF.
  - Then assert Rst_n low coincident with a write edge.
  - Required: target register reads 0; WrCount = 0.

Source files
------------

// File: rtl/regfile_onehot_wr_pkg.sv
// Shared constants for the one-hot-write register file and its select checker.
// The REGFILE_BYPASS_EN macro, when defined, enables write-to-read forwarding in the top.
package regfile_onehot_wr_pkg;

    localparam int DATA_W   = 32;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 16;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_onehot_wr_onehot_chk.sv
// One-hot checker: flags a vector with exactly one bit set and encodes that bit's index.
// The index is only meaningful when valid_o is high.
module onehot_chk #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic [N-1:0]  vec_i,
    output logic          valid_o,
    output logic [AW-1:0] idx_o
);

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign valid_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = idx_o | AW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot select, with two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_onehot_wr
    import regfile_onehot_wr_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WrEn,
    input  logic [NREGS-1:0]  WrSel,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] RdAdrA,
    input  logic [ADDR_W-1:0] RdAdrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic              SelErr,
    output logic [CNT_W-1:0]  WrCount
);

    // Register 0 has no storage; reads of address 0 are forced to zero.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic              sel_ok;
    logic [ADDR_W-1:0] wr_idx;
    logic              wr_commit;

    onehot_chk #(
        .N  (NREGS),
        .AW (ADDR_W)
    ) u_onehot_chk (
        .vec_i   (WrSel),
        .valid_o (sel_ok),
        .idx_o   (wr_idx)
    );

    assign wr_commit = WrEn && sel_ok && (wr_idx != ADDR_W'(REG_ZERO));

    always_comb begin
        sel_err_d  = sel_err_q | (WrEn & ~sel_ok);
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_commit && (wr_idx == ADDR_W'(i))) begin
                    regs_q[i] <= WrData;
                end
            end
            sel_err_q  <= sel_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        RdDataA = '0;
        RdDataB = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (RdAdrA == ADDR_W'(i)) RdDataA = regs_q[i];
            if (RdAdrB == ADDR_W'(i)) RdDataB = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_commit already excludes illegal selects and register 0.
        if (wr_commit && (RdAdrA == wr_idx)) RdDataA = WrData;
        if (wr_commit && (RdAdrB == wr_idx)) RdDataB = WrData;
`endif
    end

    assign SelErr  = sel_err_q;
    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr; inputs change on the falling edge, outputs are checked before the next rise.
module tb_regfile_onehot_wr;

    logic        Clk;
    logic        Rst_n;
    logic        WrEn;
    logic [31:0] WrSel;
    logic [31:0] WrData;
    logic [4:0]  RdAdrA;
    logic [4:0]  RdAdrB;
    logic [31:0] RdDataA;
    logic [31:0] RdDataB;
    logic        SelErr;
    logic [15:0] WrCount;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_onehot_wr dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .WrEn    (WrEn),
        .WrSel   (WrSel),
        .WrData  (WrData),
        .RdAdrA  (RdAdrA),
        .RdAdrB  (RdAdrB),
        .RdDataA (RdDataA),
        .RdDataB (RdDataB),
        .SelErr  (SelErr),
        .WrCount (WrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic apply_reset();
        @(negedge Clk);
        WrEn  = 1'b0;
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] sel, input logic [31:0] data);
        @(negedge Clk);
        WrEn   = 1'b1;
        WrSel  = sel;
        WrData = data;
        @(negedge Clk);
        WrEn   = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n  = 1'b0;
        WrEn   = 1'b0;
        WrSel  = '0;
        WrData = '0;
        RdAdrA = 5'd0;
        RdAdrB = 5'd0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        RdAdrA = 5'd1;
        RdAdrB = 5'd31;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0 || RdDataB !== 32'h0 || SelErr !== 1'b0 || WrCount !== 16'h0)
            $display("FAIL reset_state: A=%h B=%h err=%b cnt=%h, need 0/0/0/0", RdDataA, RdDataB, SelErr, WrCount);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        do_write(32'h0000_0020, 32'hDEAD_BEEF);
        RdAdrA = 5'd5;
        RdAdrB = 5'd5;
        #1;
        n_checks++;
        if (RdDataA !== 32'hDEAD_BEEF) $display("FAIL pre_reset_write: A=%h need deadbeef", RdDataA);
        else n_pass++;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0 || RdDataB !== 32'h0 || SelErr !== 1'b0 || WrCount !== 16'h0)
            $display("FAIL midrun_reset: A=%h B=%h err=%b cnt=%h, need 0/0/0/0", RdDataA, RdDataB, SelErr, WrCount);
        else n_pass++;
        // First edge after release commits a write.
        WrEn   = 1'b1;
        WrSel  = 32'h0000_0020;
        WrData = 32'h0000_00C5;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        WrEn = 1'b0;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0000_00C5 || WrCount !== 16'd1)
            $display("FAIL first_edge_write: A=%h cnt=%0d, need c5/1", RdDataA, WrCount);
        else n_pass++;
    endtask

    task automatic test_basic_write();
        apply_reset();
        do_write(32'h0000_0008, 32'h1234_5678);
        RdAdrA = 5'd3;
        RdAdrB = 5'd3;
        #1;
        n_checks++;
        if (RdDataA !== 32'h1234_5678 || RdDataB !== 32'h1234_5678 || WrCount !== 16'd1)
            $display("FAIL basic_write: A=%h B=%h cnt=%0d, need 12345678/12345678/1", RdDataA, RdDataB, WrCount);
        else n_pass++;
        do_write(32'h8000_0000, 32'h0BAD_F00D);
        RdAdrA = 5'd31;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0BAD_F00D || RdDataB !== 32'h1234_5678 || WrCount !== 16'd2)
            $display("FAIL write_reg31: A=%h B=%h cnt=%0d, need 0badf00d/12345678/2", RdDataA, RdDataB, WrCount);
        else n_pass++;
    endtask

    task automatic test_reg0();
        do_write(32'h0000_0001, 32'hFFFF_FFFF);
        RdAdrA = 5'd0;
        RdAdrB = 5'd0;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0 || RdDataB !== 32'h0 || WrCount !== 16'd2 || SelErr !== 1'b0)
            $display("FAIL reg0_protect: A=%h B=%h cnt=%0d err=%b, need 0/0/2/0", RdDataA, RdDataB, WrCount, SelErr);
        else n_pass++;
    endtask

    task automatic test_illegal();
        apply_reset();
        do_write(32'h0000_0002, 32'h1111_1111);
        do_write(32'h0000_0004, 32'h2222_2222);
        // WrEn low: select is ignored.
        @(negedge Clk);
        WrEn   = 1'b0;
        WrSel  = 32'h0000_0006;
        WrData = 32'hAAAA_AAAA;
        @(negedge Clk);
        #1;
        n_checks++;
        if (SelErr !== 1'b0) $display("FAIL illegal_wren0: err=%b need 0", SelErr);
        else n_pass++;
        do_write(32'h0000_0006, 32'hAAAA_AAAA);
        RdAdrA = 5'd1;
        RdAdrB = 5'd2;
        #1;
        n_checks++;
        if (RdDataA !== 32'h1111_1111 || RdDataB !== 32'h2222_2222 || SelErr !== 1'b1 || WrCount !== 16'd2)
            $display("FAIL illegal_multi: A=%h B=%h err=%b cnt=%0d, need 11111111/22222222/1/2", RdDataA, RdDataB, SelErr, WrCount);
        else n_pass++;
        do_write(32'h0000_0002, 32'h3333_3333);
        #1;
        n_checks++;
        if (SelErr !== 1'b1 || RdDataA !== 32'h3333_3333 || WrCount !== 16'd3)
            $display("FAIL sticky_err: err=%b A=%h cnt=%0d, need 1/33333333/3", SelErr, RdDataA, WrCount);
        else n_pass++;
        apply_reset();
        do_write(32'h0000_0000, 32'h5555_5555);
        #1;
        n_checks++;
        if (SelErr !== 1'b1 || WrCount !== 16'd0) $display("FAIL illegal_zero: err=%b cnt=%0d, need 1/0", SelErr, WrCount);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_bypass;
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h2;
`else
        exp_bypass = 32'h1;
`endif
        apply_reset();
        do_write(32'h0000_0080, 32'h1);
        @(negedge Clk);
        WrEn   = 1'b1;
        WrSel  = 32'h0000_0080;
        WrData = 32'h2;
        RdAdrA = 5'd7;
        RdAdrB = 5'd6;
        #1;
        n_checks++;
        if (RdDataA !== exp_bypass || RdDataB !== 32'h0)
            $display("FAIL same_cycle_read: A=%h B=%h, need %h/0", RdDataA, RdDataB, exp_bypass);
        else n_pass++;
        @(negedge Clk);
        WrEn   = 1'b0;
        RdAdrB = 5'd7;
        #1;
        n_checks++;
        if (RdDataA !== 32'h2 || RdDataB !== 32'h2) $display("FAIL after_edge_read: A=%h B=%h, need 2/2", RdDataA, RdDataB);
        else n_pass++;
        // An illegal select covering reg 7 must never be forwarded.
        WrEn   = 1'b1;
        WrSel  = 32'h0000_00C0;
        WrData = 32'h9;
        #1;
        n_checks++;
        if (RdDataA !== 32'h2) $display("FAIL no_fwd_illegal: A=%h need 2", RdDataA);
        else n_pass++;
        WrSel  = 32'h0000_0001;
        RdAdrA = 5'd0;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0) $display("FAIL no_fwd_reg0: A=%h need 0", RdDataA);
        else n_pass++;
        @(negedge Clk);
        WrEn = 1'b0;
    endtask

    task automatic test_saturation_race();
        apply_reset();
        @(negedge Clk);
        WrEn   = 1'b1;
        WrSel  = 32'h0000_0200;
        WrData = 32'h0000_0009;
        repeat (65535) @(negedge Clk);
        #1;
        n_checks++;
        if (WrCount !== 16'hFFFF) $display("FAIL count_65535: cnt=%h need ffff", WrCount);
        else n_pass++;
        @(negedge Clk);
        #1;
        n_checks++;
        if (WrCount !== 16'hFFFF) $display("FAIL count_saturate: cnt=%h need ffff", WrCount);
        else n_pass++;
        WrSel  = 32'h0000_0200;
        WrData = 32'h5555_AAAA;
        RdAdrA = 5'd9;
        @(posedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        WrEn = 1'b0;
        #1;
        n_checks++;
        if (RdDataA !== 32'h0 || WrCount !== 16'h0) $display("FAIL reset_race: A=%h cnt=%h, need 0/0", RdDataA, WrCount);
        else n_pass++;
        Rst_n = 1'b1;
        @(negedge Clk);
        #1;
        n_checks++;
        if (RdDataA !== 32'h0 || WrCount !== 16'h0 || SelErr !== 1'b0)
            $display("FAIL post_race: A=%h cnt=%h err=%b, need 0/0/0", RdDataA, WrCount, SelErr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_basic_write();
        test_reg0();
        test_illegal();
        test_same_cycle();
        test_saturation_race();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
